// File: rtl/rl_sched_pkg.sv
// Shared types and constants for the range-limited LJ pair scheduler.
package rl_sched_pkg;

  // Latency of the RL_LJ_Evaluation_1st_Order force pipeline, in cycles.
  localparam int LJ_PIPE_LATENCY = 24;

  // Default particle index width (64 particles per cell).
  localparam int ADDR_W = 6;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_REF  = 3'd1,
    LATCH_REF = 3'd2,
    ISSUE     = 3'd3,
    NEXT_REF  = 3'd4,
    DRAIN     = 3'd5,
    DONE      = 3'd6
  } state_e;

  // Identity of one issued pair, carried alongside it through the pipeline.
  typedef struct packed {
    logic [ADDR_W-1:0] ref_id;
    logic [ADDR_W-1:0] nb_id;
  } tag_t;

endpackage

// File: rtl/rl_pair_scheduler_if.sv
// Force-pipeline side of the pair scheduler: pair issue and tagged force return.
interface rl_pair_scheduler_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 128
);
  logic                  pipe_ivalid;
  logic [DATA_WIDTH-1:0] pipe_reference;
  logic [DATA_WIDTH-1:0] pipe_neighbor;
  logic                  pipe_ovalid;
  logic                  out_valid;
  logic [ADDR_WIDTH-1:0] out_ref_id;
  logic [ADDR_WIDTH-1:0] out_nb_id;

  // Scheduler side.
  modport master (
    output pipe_ivalid, pipe_reference, pipe_neighbor,
    output out_valid, out_ref_id, out_nb_id,
    input  pipe_ovalid
  );

  // Pipeline / force-consumer side.
  modport slave (
    input  pipe_ivalid, pipe_reference, pipe_neighbor,
    input  out_valid, out_ref_id, out_nb_id,
    output pipe_ovalid
  );
endinterface

// File: rtl/rl_tag_fifo.sv
// Tag FIFO: holds the ids of in-flight pairs; head is visible without a pop.
module rl_tag_fifo
  import rl_sched_pkg::*;
#(
  parameter int WIDTH = 2 * ADDR_W,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; writes into a full FIFO and reads from an empty one are dropped.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && !full) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop && !empty) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Tag storage.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/rl_pair_scheduler.sv
// Pair scheduler: streams every valid (i, j) pair of a home/neighbour cell pair
// into the LJ force pipeline, tags it, and matches returning forces to ids.
module rl_pair_scheduler
  import rl_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = 128,
  parameter int TAG_DEPTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   ref_count,
  input  logic [ADDR_WIDTH:0]   nb_count,
  input  logic                  same_cell,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [15:0]           pair_count,
  output logic [ADDR_WIDTH-1:0] ref_rd_addr,
  input  logic [DATA_WIDTH-1:0] ref_rd_data,
  output logic                  nb_rd_en,
  output logic [ADDR_WIDTH-1:0] nb_rd_addr,
  input  logic [DATA_WIDTH-1:0] nb_rd_data,
  rl_pair_scheduler_if.master   pif
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam int OW = $clog2(TAG_DEPTH) + 1;
  localparam int TW = 2 * ADDR_WIDTH;

  state_e                state_q, state_d;
  logic [CW-1:0]         i_q, i_d, j_q, j_d, i_inc, j_inc;
  logic [CW-1:0]         ref_cnt_q, nb_cnt_q;
  logic                  same_q;
  logic [DATA_WIDTH-1:0] ref_reg_q;
  logic                  rd_pend_q;
  logic [TW-1:0]         rd_tag_q, head;
  logic [OW-1:0]         outstanding_q;
  logic [15:0]           pair_count_q;
  logic                  err_q;
  logic                  load_cfg, load_ref, skip, credit_ok;
  logic                  push, pop, fifo_full, fifo_empty;

  assign i_inc     = i_q + CW'(1);
  assign j_inc     = j_q + CW'(1);
  assign skip      = same_q && (j_q == i_q);
  // A read already in flight to the pipeline input holds a credit too.
  assign credit_ok = (outstanding_q + OW'(rd_pend_q)) < OW'(TAG_DEPTH);
  assign push      = rd_pend_q && !fifo_full;
  assign pop       = pif.pipe_ovalid && !fifo_empty;

  // Next-state logic for the row/column walk.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    nb_rd_en = 1'b0;
    load_cfg = 1'b0;
    load_ref = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load_cfg = 1'b1;
          i_d      = '0;
          state_d  = (ref_count == '0 || nb_count == '0) ? DONE : LOAD_REF;
        end
      end
      LOAD_REF:  state_d = LATCH_REF;
      LATCH_REF: begin
        load_ref = 1'b1;
        j_d      = '0;
        state_d  = ISSUE;
      end
      ISSUE: begin
        if (skip || credit_ok) begin
          nb_rd_en = !skip;
          j_d      = j_inc;
          if (j_inc == nb_cnt_q) state_d = NEXT_REF;
        end
      end
      NEXT_REF: begin
        i_d     = i_inc;
        state_d = (i_inc == ref_cnt_q) ? DRAIN : LOAD_REF;
      end
      DRAIN:   if (outstanding_q == '0 && !rd_pend_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Run state, captured configuration, issue stage and in-flight bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      i_q           <= '0;
      j_q           <= '0;
      ref_cnt_q     <= '0;
      nb_cnt_q      <= '0;
      same_q        <= 1'b0;
      ref_reg_q     <= '0;
      rd_pend_q     <= 1'b0;
      rd_tag_q      <= '0;
      outstanding_q <= '0;
      pair_count_q  <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      rd_pend_q <= nb_rd_en;
      if (nb_rd_en) rd_tag_q <= {i_q[ADDR_WIDTH-1:0], j_q[ADDR_WIDTH-1:0]};
      if (load_cfg) begin
        ref_cnt_q <= ref_count;
        nb_cnt_q  <= nb_count;
        same_q    <= same_cell;
      end
      // ref_reg holds through NEXT_REF so the row's last pair still sees its reference.
      if (load_ref) ref_reg_q <= ref_rd_data;
      if (load_cfg)       pair_count_q <= '0;
      else if (rd_pend_q) pair_count_q <= pair_count_q + 16'd1;
      case ({push, pop})
        2'b10:   outstanding_q <= outstanding_q + OW'(1);
        2'b01:   outstanding_q <= outstanding_q - OW'(1);
        default: outstanding_q <= outstanding_q;
      endcase
      if (pif.pipe_ovalid && fifo_empty) err_q <= 1'b1;
    end
  end

  rl_tag_fifo #(
    .WIDTH (TW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (rd_tag_q),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign err         = err_q;
  assign pair_count  = pair_count_q;
  assign ref_rd_addr = i_q[ADDR_WIDTH-1:0];
  assign nb_rd_addr  = j_q[ADDR_WIDTH-1:0];

  assign pif.pipe_ivalid    = rd_pend_q;
  assign pif.pipe_reference = ref_reg_q;
  assign pif.pipe_neighbor  = rd_pend_q ? nb_rd_data : '0;
  assign pif.out_valid      = pif.pipe_ovalid;
  // Ids stay zero unless a real tag is popped this cycle.
  assign pif.out_ref_id     = pop ? head[TW-1:ADDR_WIDTH] : '0;
  assign pif.out_nb_id      = pop ? head[ADDR_WIDTH-1:0]  : '0;

endmodule
